// File: rtl/mem_pkg.sv
// Shared definitions for the byte-lane data memory: access-size encodings,
// default window base and the lane enable / alignment / extension helpers.
package mem_pkg;

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;

    // Lane k covers bits [8k+7:8k]; the reserved size enables nothing.
    function automatic logic [3:0] build_byte_enable(
        input logic [1:0] size,
        input logic [1:0] offset
    );
        logic [3:0] enable;
        case (size)
            SIZE_BYTE: enable = 4'b0001 << offset;
            SIZE_HALF: enable = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: enable = 4'b1111;
            default:   enable = 4'b0000;
        endcase
        return enable;
    endfunction

    // Replicate right-justified store data so every candidate lane sees it.
    function automatic logic [31:0] align_store_data(
        input logic [1:0]  size,
        input logic [31:0] data
    );
        logic [31:0] aligned;
        case (size)
            SIZE_BYTE: aligned = {4{data[7:0]}};
            SIZE_HALF: aligned = {2{data[15:0]}};
            SIZE_WORD: aligned = data;
            default:   aligned = 32'h0000_0000;
        endcase
        return aligned;
    endfunction

    // Move the addressed lane(s) down to bit 0, then sign- or zero-extend.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  offset,
        input logic        unsignedFlag
    );
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {offset, 3'b000};
        case (size)
            SIZE_BYTE: result = unsignedFlag ? {24'h00_0000, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = unsignedFlag ? {16'h0000, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            SIZE_WORD: result = word;
            default:   result = 32'h0000_0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/bytelane_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module bytelane_ram #(
    parameter int MEMORY_DEPTH = 256,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic [3:0]            byteEnable,
    input  logic                  readEnable,
    input  logic [ADDR_WIDTH-1:0] wordIndex,
    input  logic [31:0]           writeData,
    output logic [31:0]           readData
);

    logic [31:0] mem_r [0:MEMORY_DEPTH-1];

    // Byte-lane writes and read-data capture; the read only updates when asked,
    // so the captured word stays put while a response is being held.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (byteEnable[lane]) begin
                mem_r[wordIndex][8*lane +: 8] <= writeData[8*lane +: 8];
            end
        end
        if (readEnable) begin
            readData <= mem_r[wordIndex];
        end
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// MEM-stage data memory with byte/half/word accesses, a checked address window
// and a valid/ready request/response handshake holding one response.
module data_memory_bytelane
    import mem_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 256,
    parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rsp_misaligned,
    output logic                  rsp_out_of_range
);

    localparam int          ADDR_WIDTH   = $clog2(MEMORY_DEPTH);
    localparam logic [31:0] WINDOW_BYTES = 32'(MEMORY_DEPTH * 4);

    if (DATA_WIDTH != 32) begin : gDataWidthCheck
        $error("data_memory_bytelane: byte-lane logic supports DATA_WIDTH = 32 only");
    end

    logic                  accept_s;
    logic [31:0]           offset_s;
    logic                  misaligned_s;
    logic                  outOfRange_s;
    logic                  storeOk_s;
    logic                  loadEnable_s;
    logic [3:0]            byteEnable_s;
    logic [ADDR_WIDTH-1:0] wordIndex_s;
    logic [31:0]           storeData_s;
    logic [31:0]           ramReadData_s;
    logic [31:0]           readData_s;

    logic                  rspValid_r;
    logic                  rspMisaligned_r;
    logic                  rspOutOfRange_r;
    logic                  rspLoadOk_r;
    logic                  rspUnsigned_r;
    logic [1:0]            rspSize_r;
    logic [1:0]            rspOffset_r;

    assign req_ready = !rspValid_r || rsp_ready;

    // Address decode and error classification for the request on the bus.
    always_comb begin
        accept_s    = req_valid && req_ready;
        offset_s    = address - BASE_ADDRESS;
        // Unsigned compare: addresses below the base wrap and flag as well.
        outOfRange_s = (offset_s >= WINDOW_BYTES);
        case (req_size)
            SIZE_BYTE: misaligned_s = 1'b0;
            SIZE_HALF: misaligned_s = offset_s[0];
            SIZE_WORD: misaligned_s = (offset_s[1:0] != 2'b00);
            default:   misaligned_s = 1'b1;
        endcase
        wordIndex_s = offset_s[ADDR_WIDTH+1:2];
        storeData_s = align_store_data(req_size, write_data);
    end

    // RAM strobes; reset in the accept cycle suppresses both write and read.
    always_comb begin
        storeOk_s    = accept_s && req_write && !misaligned_s && !outOfRange_s && !reset;
        loadEnable_s = accept_s && !req_write && !reset;
        if (storeOk_s) begin
            byteEnable_s = build_byte_enable(req_size, offset_s[1:0]);
        end else begin
            byteEnable_s = 4'b0000;
        end
    end

    bytelane_ram #(
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) uRam (
        .clk        (clk),
        .byteEnable (byteEnable_s),
        .readEnable (loadEnable_s),
        .wordIndex  (wordIndex_s),
        .writeData  (storeData_s),
        .readData   (ramReadData_s)
    );

    // Response register: loads on accept, retires on rsp_ready, else holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            rspValid_r      <= 1'b0;
            rspMisaligned_r <= 1'b0;
            rspOutOfRange_r <= 1'b0;
            rspLoadOk_r     <= 1'b0;
            rspUnsigned_r   <= 1'b0;
            rspSize_r       <= 2'b00;
            rspOffset_r     <= 2'b00;
        end else if (accept_s) begin
            rspValid_r      <= 1'b1;
            rspMisaligned_r <= misaligned_s;
            rspOutOfRange_r <= outOfRange_s;
            rspLoadOk_r     <= !req_write && !misaligned_s && !outOfRange_s;
            rspUnsigned_r   <= req_unsigned;
            rspSize_r       <= req_size;
            rspOffset_r     <= offset_s[1:0];
        end else if (rsp_ready) begin
            rspValid_r      <= 1'b0;
        end
    end

    // Lane extraction works only from registered state, so no req_* reaches rsp_*.
    always_comb begin
        if (rspLoadOk_r) begin
            readData_s = extend_load(ramReadData_s, rspSize_r, rspOffset_r, rspUnsigned_r);
        end else begin
            readData_s = 32'h0000_0000;
        end
    end

    assign rsp_valid        = rspValid_r;
    assign rsp_misaligned   = rspMisaligned_r;
    assign rsp_out_of_range = rspOutOfRange_r;
    assign read_data        = readData_s;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Self-checking bench for data_memory_bytelane: directed scenarios plus a
// randomized back-to-back stream checked against a byte-array reference model.
module tb_data_memory_bytelane;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 256;
    localparam int          NBYTES = DEPTH * 4;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic        useModel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
        logic        oor;
    } vec_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
        logic        oor;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] read_data;
    logic        rsp_misaligned;
    logic        rsp_out_of_range;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] mdl [0:NBYTES-1];

    data_memory_bytelane #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (DEPTH),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .address          (address),
        .write_data       (write_data),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .read_data        (read_data),
        .rsp_misaligned   (rsp_misaligned),
        .rsp_out_of_range (rsp_out_of_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference: memory as a flat little-endian byte array.
    task automatic model_access(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output exp_t e);
        logic [31:0] off;
        logic [31:0] val;
        logic [31:0] mask;
        int n;
        off = addr - BASE;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        e.oor = (off >= 32'(NBYTES));
        e.mis = (sz == 2'b11) || ((off % 32'(n)) != 32'd0);
        e.rd = 32'h0;
        if (!e.mis && !e.oor) begin
            if (wr) begin
                for (int i = 0; i < n; i++) mdl[off + 32'(i)] = wd[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < n; i++) val = val | ({24'h0, mdl[off + 32'(i)]} << (8*i));
                mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
                if (!uns && n < 4 && val[8*n-1]) val = val | ~mask;
                e.rd = val;
            end
        end
    endtask

    // Drives one request with rsp_ready=1 and returns the response seen one cycle later.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic vld, output exp_t got);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        address = addr; write_data = wd; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        vld = rsp_valid;
        got.rd = read_data; got.mis = rsp_misaligned; got.oor = rsp_out_of_range;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        nCompared++;
        if ({rsp_valid, read_data, rsp_misaligned, rsp_out_of_range, req_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            nMismatched++;
            $display("FAIL reset_state: got valid=%0b data=%h mis=%0b oor=%0b rdy=%0b, want 0/0/0/0/1",
                     rsp_valid, read_data, rsp_misaligned, rsp_out_of_range, req_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        exp_t e, got;
        logic vld;
        logic [31:0] wd;
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom();
            model_access(1'b1, 2'b10, 1'b0, BASE + 32'(4*w), wd, e);
            do_req(1'b1, 2'b10, 1'b0, BASE + 32'(4*w), wd, vld, got);
            nCompared++;
            if ({vld, got} !== {1'b1, e}) begin
                nMismatched++;
                $display("FAIL fill_store[%0d]: got v=%0b %h/%0b/%0b, want v=1 %h/%0b/%0b",
                         w, vld, got.rd, got.mis, got.oor, e.rd, e.mis, e.oor);
            end
        end
    endtask

    task automatic test_word_and_lanes();
        vec_t t [0:9];
        exp_t e, got, want;
        logic vld;
        t[0] = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0};
        t[1] = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h1001_0004, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0};
        t[2] = '{1'b0, 2'b00, 1'b0, 1'b0, 32'h1001_0007, 32'h0,        32'hFFFF_FFDE, 1'b0, 1'b0};
        t[3] = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h1001_0007, 32'h0,        32'h0000_00DE, 1'b0, 1'b0};
        t[4] = '{1'b1, 2'b00, 1'b0, 1'b0, 32'h1001_0005, 32'h0000_0011, 32'h0000_0000, 1'b0, 1'b0};
        t[5] = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h1001_0004, 32'h0,        32'hDEAD_11EF, 1'b0, 1'b0};
        t[6] = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h1001_0006, 32'h0000_8001, 32'h0000_0000, 1'b0, 1'b0};
        t[7] = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h1001_0006, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0};
        t[8] = '{1'b0, 2'b01, 1'b1, 1'b0, 32'h1001_0006, 32'h0,        32'h0000_8001, 1'b0, 1'b0};
        t[9] = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h1001_0004, 32'h0,        32'h8001_11EF, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            model_access(t[i].wr, t[i].sz, t[i].uns, t[i].addr, t[i].wd, e);
            do_req(t[i].wr, t[i].sz, t[i].uns, t[i].addr, t[i].wd, vld, got);
            want = t[i].useModel ? e : exp_t'({t[i].rd, t[i].mis, t[i].oor});
            nCompared++;
            if ({vld, got} !== {1'b1, want}) begin
                nMismatched++;
                $display("FAIL lanes[%0d]: got v=%0b %h/%0b/%0b, want v=1 %h/%0b/%0b",
                         i, vld, got.rd, got.mis, got.oor, want.rd, want.mis, want.oor);
            end
        end
    endtask

    task automatic test_errors();
        vec_t t [0:9];
        exp_t e, got, want;
        logic vld;
        t[0] = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h1001_0002, 32'h0,         32'h0, 1'b1, 1'b0};
        t[1] = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h1000_FFFC, 32'h1234_5678, 32'h0, 1'b0, 1'b1};
        t[2] = '{1'b0, 2'b10, 1'b0, 1'b1, 32'h1001_0000, 32'h0,         32'h0, 1'b0, 1'b0};
        t[3] = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h1001_0401, 32'h0000_ABCD, 32'h0, 1'b1, 1'b1};
        t[4] = '{1'b0, 2'b10, 1'b0, 1'b0, 32'h1001_0400, 32'h0,         32'h0, 1'b0, 1'b1};
        t[5] = '{1'b0, 2'b10, 1'b0, 1'b1, 32'h1001_03FC, 32'h0,         32'h0, 1'b0, 1'b0};
        t[6] = '{1'b0, 2'b00, 1'b1, 1'b1, 32'h1001_03FF, 32'h0,         32'h0, 1'b0, 1'b0};
        t[7] = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h1001_0010, 32'h0,         32'h0, 1'b1, 1'b0};
        t[8] = '{1'b1, 2'b01, 1'b0, 1'b0, 32'h1001_0003, 32'h0000_5555, 32'h0, 1'b1, 1'b0};
        t[9] = '{1'b0, 2'b10, 1'b0, 1'b1, 32'h1001_0000, 32'h0,         32'h0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            model_access(t[i].wr, t[i].sz, t[i].uns, t[i].addr, t[i].wd, e);
            do_req(t[i].wr, t[i].sz, t[i].uns, t[i].addr, t[i].wd, vld, got);
            want = t[i].useModel ? e : exp_t'({t[i].rd, t[i].mis, t[i].oor});
            nCompared++;
            if ({vld, got} !== {1'b1, want}) begin
                nMismatched++;
                $display("FAIL errors[%0d]: got v=%0b %h/%0b/%0b, want v=1 %h/%0b/%0b",
                         i, vld, got.rd, got.mis, got.oor, want.rd, want.mis, want.oor);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        model_access(1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, e1);
        model_access(1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'h0, e2);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        address = 32'h1001_0004; write_data = 32'h0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        // Second request waits on the bus while the first response is held.
        req_size = 2'b01; req_unsigned = 1'b1; address = 32'h1001_0006;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nCompared++;
            if ({rsp_valid, req_ready, read_data, rsp_misaligned, rsp_out_of_range} !== {1'b1, 1'b0, e1}) begin
                nMismatched++;
                $display("FAIL hold[%0d]: got v=%0b rdy=%0b %h/%0b/%0b, want v=1 rdy=0 %h/%0b/%0b",
                         k, rsp_valid, req_ready, read_data, rsp_misaligned, rsp_out_of_range, e1.rd, e1.mis, e1.oor);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        nCompared++;
        if ({rsp_valid, req_ready} !== 2'b11) begin
            nMismatched++;
            $display("FAIL release_ready: got v=%0b rdy=%0b, want v=1 rdy=1", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({rsp_valid, read_data, rsp_misaligned, rsp_out_of_range} !== {1'b1, e2}) begin
            nMismatched++;
            $display("FAIL overlap_rsp: got v=%0b %h/%0b/%0b, want v=1 %h/%0b/%0b",
                     rsp_valid, read_data, rsp_misaligned, rsp_out_of_range, e2.rd, e2.mis, e2.oor);
        end
        @(posedge clk); #1;
        @(negedge clk);
        nCompared++;
        if (rsp_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL retire: got rsp_valid=%0b, want 0", rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        localparam int N = 200;
        exp_t q [$];
        exp_t e, want;
        logic [31:0] off;
        logic [31:0] r;
        logic [1:0]  sz;
        int nRsp;
        nRsp = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c <= N + 1; c++) begin
            if (c < N) begin
                r   = $urandom_range(0, 2);
                sz  = r[1:0];
                off = $urandom_range(0, NBYTES - 1);
                r   = $urandom_range(0, 11);
                if (r == 32'd0)       off = $urandom();
                else if (r == 32'd1)  sz = 2'b11;
                else if (r > 32'd2)   off = off & ~((32'd1 << sz) - 32'd1);
                req_valid = 1'b1; req_write = $urandom_range(0, 1) == 1;
                req_size = sz; req_unsigned = $urandom_range(0, 1) == 1;
                address = BASE + off; write_data = $urandom();
                model_access(req_write, req_size, req_unsigned, address, write_data, e);
                q.push_back(e);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 1 && c <= N) begin
                want = q.pop_front();
                nRsp++;
                nCompared++;
                if ({rsp_valid, req_ready, read_data, rsp_misaligned, rsp_out_of_range} !== {1'b1, 1'b1, want}) begin
                    nMismatched++;
                    $display("FAIL b2b[%0d]: got v=%0b rdy=%0b %h/%0b/%0b, want v=1 rdy=1 %h/%0b/%0b",
                             c - 1, rsp_valid, req_ready, read_data, rsp_misaligned, rsp_out_of_range,
                             want.rd, want.mis, want.oor);
                end
            end else if (c == N + 1) begin
                nCompared++;
                if ({rsp_valid, nRsp} !== {1'b0, N}) begin
                    nMismatched++;
                    $display("FAIL b2b_drain: got rsp_valid=%0b responses=%0d, want 0 and %0d", rsp_valid, nRsp, N);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midop();
        exp_t e, got;
        logic vld;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        address = 32'h1001_0008; write_data = 32'h0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        nCompared++;
        if (rsp_valid !== 1'b1) begin
            nMismatched++;
            $display("FAIL midop_pending: got rsp_valid=%0b, want 1", rsp_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        address = 32'h1001_0008; write_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({rsp_valid, read_data, rsp_misaligned, rsp_out_of_range} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("FAIL midop_reset: got v=%0b %h/%0b/%0b, want all 0",
                     rsp_valid, read_data, rsp_misaligned, rsp_out_of_range);
        end
        @(posedge clk); #1;
        model_access(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, e);
        do_req(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, vld, got);
        nCompared++;
        if ({vld, got} !== {1'b1, e}) begin
            nMismatched++;
            $display("FAIL midop_store_suppressed: got v=%0b %h, want v=1 %h", vld, got.rd, e.rd);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; address = 32'h0; write_data = 32'h0; rsp_ready = 1'b0;
        test_reset();
        test_fill();
        test_word_and_lanes();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
